// File: rtl/alu_md_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_unit_pkg
//  Purpose  : Op codes, FSM encoding and operand-signedness helpers shared
//             by the RV32M multiply/divide execute unit.
//  Revision : 1.0  initial release
// ============================================================================
package alu_md_unit_pkg;

    localparam int unsigned c_MD_OP_WIDTH = 3;

    // funct3 encoding of the M extension
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    localparam logic [1:0] c_MD_IDLE = 2'd0;
    localparam logic [1:0] c_MD_CALC = 2'd1;
    localparam logic [1:0] c_MD_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_MD_IDLE,
        ST_CALC = c_MD_CALC,
        ST_DONE = c_MD_DONE
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_s1_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_s2_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_unit_if
//  Purpose  : Request/response handshake bundle between EX and the M unit.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_md_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int MD_OP_WIDTH = 3
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [MD_OP_WIDTH-1:0] md_op;
    logic [DATA_WIDTH-1:0]  s1;
    logic [DATA_WIDTH-1:0]  s2;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  md_result;
    logic                   md_busy;

    modport master (
        output flush, in_valid, md_op, s1, s2, out_ready,
        input  in_ready, out_valid, md_result, md_busy
    );

    modport slave (
        input  flush, in_valid, md_op, s1, s2, out_ready,
        output in_ready, out_valid, md_result, md_busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_md_unit_md_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : md_iter_core
//  Purpose  : Combinational BITS_PER_CYCLE step of shift-add multiply or
//             restoring divide on a packed {hi, lo} accumulator.
//  Revision : 1.0  initial release
// ============================================================================
module md_iter_core #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire logic                    i_is_div,
    input  wire logic [DATA_WIDTH-1:0]   i_operand,
    input  wire logic [2*DATA_WIDTH-1:0] i_acc,
    output logic      [2*DATA_WIDTH-1:0] o_acc
);
    logic [2*DATA_WIDTH-1:0] w_stage [0:BITS_PER_CYCLE];

    assign w_stage[0] = i_acc;

    // mul: {hi, multiplier}, add into hi then shift right.
    // div: {remainder, dividend}, shift left and subtract when it fits.
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
        logic [DATA_WIDTH:0]   w_mul_sum;
        logic [DATA_WIDTH:0]   w_div_rem;
        logic [DATA_WIDTH-1:0] w_div_diff;
        logic                  w_div_ge;

        assign w_mul_sum  = {1'b0, w_stage[gi][2*DATA_WIDTH-1:DATA_WIDTH]}
                          + (w_stage[gi][0] ? {1'b0, i_operand} : {(DATA_WIDTH+1){1'b0}});
        assign w_div_rem  = {w_stage[gi][2*DATA_WIDTH-1:DATA_WIDTH], w_stage[gi][DATA_WIDTH-1]};
        assign w_div_ge   = (w_div_rem >= {1'b0, i_operand});
        assign w_div_diff = w_div_rem[DATA_WIDTH-1:0] - i_operand;

        assign w_stage[gi+1] = i_is_div
            ? {(w_div_ge ? w_div_diff : w_div_rem[DATA_WIDTH-1:0]),
               w_stage[gi][DATA_WIDTH-2:0], w_div_ge}
            : {w_mul_sum, w_stage[gi][DATA_WIDTH-1:1]};
    end

    assign o_acc = w_stage[BITS_PER_CYCLE];
endmodule
`default_nettype wire

// File: rtl/alu_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_unit
//  Purpose  : Multi-cycle RV32M multiply/divide/remainder unit for EX.
//  Revision : 1.0  initial release
// ============================================================================
module alu_md_unit
    import alu_md_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int MD_OP_WIDTH    = c_MD_OP_WIDTH
) (
    input  wire logic    clk,
    input  wire logic    rst,
    alu_md_unit_if.slave bus
);
    localparam int c_STEPS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_STEPS);
    localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(c_STEPS - 1);
    localparam logic [DATA_WIDTH-1:0] c_MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    md_state_e                 r_state;
    md_state_e                 w_state_nxt;
    md_op_e                    r_op;
    md_op_e                    w_op;
    logic [MD_OP_WIDTH-1:0]    w_op_raw;
    logic                      r_neg_q;
    logic                      r_neg_r;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]     r_operand;
    logic [2*DATA_WIDTH-1:0]   r_acc;
    logic [2*DATA_WIDTH-1:0]   w_acc_next;
    logic [DATA_WIDTH-1:0]     r_result;

    logic                      w_in_div;
    logic                      w_s1_neg;
    logic                      w_s2_neg;
    logic [DATA_WIDTH-1:0]     w_s1_mag;
    logic [DATA_WIDTH-1:0]     w_s2_mag;
    logic                      w_div_zero;
    logic                      w_overflow;
    logic                      w_special;
    logic [DATA_WIDTH-1:0]     w_special_result;
    logic                      w_accept;
    logic                      w_load_result;
    logic [2*DATA_WIDTH-1:0]   w_prod;
    logic [DATA_WIDTH-1:0]     w_quot;
    logic [DATA_WIDTH-1:0]     w_rem;
    logic [DATA_WIDTH-1:0]     w_calc_result;

    // ---------------- operand decode at accept ----------------
    assign w_op_raw   = bus.md_op;
    assign w_op       = md_op_e'(w_op_raw[2:0]);
    assign w_in_div   = op_is_div(w_op);
    assign w_s1_neg   = op_s1_signed(w_op) & bus.s1[DATA_WIDTH-1];
    assign w_s2_neg   = op_s2_signed(w_op) & bus.s2[DATA_WIDTH-1];
    assign w_s1_mag   = w_s1_neg ? -bus.s1 : bus.s1;
    assign w_s2_mag   = w_s2_neg ? -bus.s2 : bus.s2;
    assign w_div_zero = w_in_div && (bus.s2 == '0);
    assign w_overflow = ((w_op == MD_DIV) || (w_op == MD_REM))
                        && (bus.s1 == c_MOST_NEG) && (bus.s2 == '1);
    assign w_special  = w_div_zero | w_overflow;

    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = ((w_op == MD_DIV) || (w_op == MD_DIVU)) ? '1 : bus.s1;
        end else if (w_overflow) begin
            w_special_result = (w_op == MD_DIV) ? bus.s1 : '0;
        end
    end

    // ---------------- iteration and result sign correction ----------------
    md_iter_core #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_iter (
        .i_is_div  (op_is_div(r_op)),
        .i_operand (r_operand),
        .i_acc     (r_acc),
        .o_acc     (w_acc_next)
    );

    assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;
    assign w_quot = r_neg_q ? -w_acc_next[DATA_WIDTH-1:0] : w_acc_next[DATA_WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH]
                            :  w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH];

    always_comb begin
        w_calc_result = '0;
        case (r_op)
            MD_MUL:                       w_calc_result = w_prod[DATA_WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_calc_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            MD_DIV, MD_DIVU:              w_calc_result = w_quot;
            default:                      w_calc_result = w_rem;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_load_result = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_load_result = !bus.flush;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // flush dominates every transition, including a completing handshake
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= MD_MUL;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_op      <= w_op;
            r_neg_q   <= w_s1_neg ^ w_s2_neg;
            r_neg_r   <= w_s1_neg;
            r_cnt     <= '0;
            r_operand <= w_in_div ? w_s2_mag : w_s1_mag;
            r_acc     <= {{DATA_WIDTH{1'b0}}, (w_in_div ? w_s1_mag : w_s2_mag)};
            if (w_special) begin
                r_result <= w_special_result;
            end
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_load_result) begin
                r_result <= w_calc_result;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.md_busy   = (r_state == ST_CALC) || (r_state == ST_DONE);
    assign bus.md_result = r_result;

endmodule
`default_nettype wire
